lsu_dmem_master: RTL and testbench

- Load/store unit that issues requests to d_mem (memRead/memWrite/dataAddress/writeMemData) and consumes readMemData.
- Sits in the MEM stage between the datapath and d_mem.
- Converts byte-addressed CPU load/store requests of byte, half or word size into word accesses.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Reports misaligned or illegal accesses without touching memory.

---
 rtl/lsu_dmem_master_if.sv | 41 ++++
 rtl/lsu_dmem_master.sv | 166 ++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_master_if.sv
// CPU-request / response / d_mem bus bundle for lsu_dmem_master.
// master = the load/store unit, slave = the datapath plus d_mem side.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef logDepthMem
`define logDepthMem 10
`endif

interface lsu_dmem_master_if #(
  parameter int unsigned WIDTH  = `DWIDTH,
  parameter int unsigned ADDR_W = `logDepthMem
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              resp_valid;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] dataAddress;
  logic [WIDTH-1:0]  writeMemData;
  logic              memRead;
  logic              memWrite;
  logic [WIDTH-1:0]  readMemData;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, readMemData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dataAddress, writeMemData, memRead, memWrite
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, readMemData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dataAddress, writeMemData, memRead, memWrite
  );
endinterface

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store unit: byte/half/word CPU accesses mapped onto word-wide d_mem.
// Sub-word loads/stores (lane extraction, read-modify-write) exist only with LSU_SUBWORD_EN.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef logDepthMem
`define logDepthMem 10
`endif

module lsu_dmem_master #(
  parameter int unsigned WIDTH  = `DWIDTH,
  parameter int unsigned ADDR_W = `logDepthMem
) (
  input  logic                clk,
  input  logic                rst,
  lsu_dmem_master_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE, ST_WR, LD_RD, LD_CAP, RMW_RD, RMW_CAP, RMW_WR, RESP
  } state_t;

  state_t state;
  logic   misalign;

`ifdef LSU_SUBWORD_EN
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic             uns_q;
  logic [WIDTH-1:0] wdata_q;

  function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] word,
                                               input logic [1:0] size,
                                               input logic [1:0] lane,
                                               input logic uns);
    logic [WIDTH-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   extract = {{(WIDTH-8){sh[7] & ~uns}}, sh[7:0]};
      2'b01:   extract = {{(WIDTH-16){sh[15] & ~uns}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] word,
                                             input logic [WIDTH-1:0] wdata,
                                             input logic [1:0] size,
                                             input logic [1:0] lane);
    logic [WIDTH-1:0] mask;
    mask = (size == 2'b00) ? {{(WIDTH-8){1'b0}}, 8'hFF} : {{(WIDTH-16){1'b0}}, 16'hFFFF};
    merge = (word & ~(mask << {lane, 3'b000})) | ((wdata & mask) << {lane, 3'b000});
  endfunction
`endif

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_SUBWORD_EN
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
      default: misalign = 1'b1;
    endcase
`else
    misalign = (bus.req_size != 2'b10) || (|bus.req_addr[1:0]);
`endif
  end

  assign bus.req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.memRead      <= 1'b0;
      bus.memWrite     <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_err     <= 1'b0;
      bus.dataAddress  <= '0;
      bus.writeMemData <= '0;
      bus.resp_rdata   <= '0;
`ifdef LSU_SUBWORD_EN
      size_q  <= '0;
      lane_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.dataAddress <= bus.req_addr[ADDR_W+1:2];
`ifdef LSU_SUBWORD_EN
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
`endif
            if (misalign) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= RESP;
            end else if (bus.req_we && bus.req_size == 2'b10) begin
              bus.memWrite     <= 1'b1;
              bus.writeMemData <= bus.req_wdata;
              state            <= ST_WR;
            end else begin
              // sub-word stores also start with a read: the other lanes must be preserved
              bus.memRead <= 1'b1;
`ifdef LSU_SUBWORD_EN
              state <= bus.req_we ? RMW_RD : LD_RD;
`else
              state <= LD_RD;
`endif
            end
          end
        end
        ST_WR: begin
          bus.memWrite   <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          state          <= RESP;
        end
        LD_RD: begin
          bus.memRead <= 1'b0;
          state       <= LD_CAP;
        end
        LD_CAP: begin
`ifdef LSU_SUBWORD_EN
          bus.resp_rdata <= extract(bus.readMemData, size_q, lane_q, uns_q);
`else
          bus.resp_rdata <= bus.readMemData;
`endif
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          state          <= RESP;
        end
`ifdef LSU_SUBWORD_EN
        RMW_RD: begin
          bus.memRead <= 1'b0;
          state       <= RMW_CAP;
        end
        RMW_CAP: begin
          bus.writeMemData <= merge(bus.readMemData, wdata_q, size_q, lane_q);
          bus.memWrite     <= 1'b1;
          state            <= RMW_WR;
        end
        RMW_WR: begin
          bus.memWrite   <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          state          <= RESP;
        end
`endif
        RESP: begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master: vector table through a response scoreboard,
// plus hand sequences for reset, back-to-back requests and abort-by-reset.
`ifndef logDepthMem
`define logDepthMem 10
`endif

module tb_lsu_dmem_master;
  localparam int unsigned ADDR_W = `logDepthMem;
  localparam int unsigned AW2    = ADDR_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_dmem_master_if bus ();
  lsu_dmem_master dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string           nm;
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic [AW2-1:0]  addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            err;
    int              lat;
    int              nrd;
    int              nwr;
    logic [31:0]     wd;
  } vec_t;

  typedef struct {
    logic [31:0]       rdata;
    logic              err;
    int                lat;
    int                nrd;
    int                nwr;
    logic [31:0]       wd;
    logic [ADDR_W-1:0] wa;
  } obs_t;

  vec_t exp_q[$];
  obs_t obs_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  int   nrd = 0;
  int   nwr = 0;
  logic [31:0]       last_wd = '0;
  logic [ADDR_W-1:0] last_wa = '0;
  logic              overlap = 1'b0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // word-wide d_mem with one-cycle read latency
  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.dataAddress] <= bus.writeMemData;
    if (bus.memRead)  bus.readMemData <= mem[bus.dataAddress];
  end

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (rst) begin
      acc_q.delete();
      nrd <= 0;
      nwr <= 0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_q.push_back(ncyc);
      if (bus.memRead && bus.memWrite) overlap <= 1'b1;
      if (bus.resp_valid) begin
        obs_q.push_back('{rdata: bus.resp_rdata, err: bus.resp_err,
                          lat: (acc_q.size() != 0) ? (ncyc - acc_q.pop_front()) : -1,
                          nrd: nrd, nwr: nwr, wd: last_wd, wa: last_wa});
        nrd <= 0;
        nwr <= 0;
      end else begin
        if (bus.memRead) nrd <= nrd + 1;
        if (bus.memWrite) begin
          nwr     <= nwr + 1;
          last_wd <= bus.writeMemData;
          last_wa <= bus.dataAddress;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t ld(string nm, logic [1:0] size, logic uns, int addr, logic [31:0] rdata);
    vec_t v;
    v.nm = nm; v.we = 1'b0; v.size = size; v.uns = uns; v.addr = AW2'(addr);
    v.wdata = 32'h5A5A_5A5A; v.rdata = rdata; v.err = 1'b0;
    v.lat = 3; v.nrd = 1; v.nwr = 0; v.wd = '0;
    return v;
  endfunction

  function automatic vec_t st(string nm, logic [1:0] size, int addr, logic [31:0] wdata, logic [31:0] merged);
    vec_t v;
    v.nm = nm; v.we = 1'b1; v.size = size; v.uns = 1'b0; v.addr = AW2'(addr);
    v.wdata = wdata; v.rdata = '0; v.err = 1'b0; v.nwr = 1; v.wd = merged;
    v.lat = (size == 2'b10) ? 2 : 4;
    v.nrd = (size == 2'b10) ? 0 : 1;
    return v;
  endfunction

  function automatic vec_t er(string nm, logic we, logic [1:0] size, int addr);
    vec_t v;
    v.nm = nm; v.we = we; v.size = size; v.uns = 1'b0; v.addr = AW2'(addr);
    v.wdata = 32'hFFFF_FFFF; v.rdata = '0; v.err = 1'b1;
    v.lat = 1; v.nrd = 0; v.nwr = 0; v.wd = '0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept got=timeout want=req_ready", nm);
    end
  endtask

  task automatic issue(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk); #1;
    wait_ready(v.nm);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() != 0) begin
      int n = 0;
      while (obs_q.size() == 0 && n < 30) begin
        @(negedge clk); #1;
        n++;
      end
      if (obs_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_resp got=timeout want=resp_valid", exp_q[0].nm);
        exp_q.delete();
      end else begin
        vec_t e;
        obs_t o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        chk({e.nm, "_err"},   64'(o.err),   64'(e.err));
        chk({e.nm, "_rdata"}, 64'(o.rdata), 64'(e.rdata));
        chk({e.nm, "_lat"},   64'(o.lat),   64'(e.lat));
        chk({e.nm, "_nrd"},   64'(o.nrd),   64'(e.nrd));
        chk({e.nm, "_nwr"},   64'(o.nwr),   64'(e.nwr));
        if (e.nwr != 0) begin
          chk({e.nm, "_wdata"}, 64'(o.wd), 64'(e.wd));
          chk({e.nm, "_waddr"}, 64'(o.wa), 64'(e.addr[AW2-1:2]));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] c1, c2;
`ifdef LSU_SUBWORD_EN
    c1 = 32'h1122_AB44;
    c2 = 32'hCAFE_AB7F;
`else
    c1 = 32'h1122_3344;
    c2 = 32'h1122_3344;
`endif
    tbl.push_back(st("sw_08",     2'b10, 'h008, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    tbl.push_back(ld("lw_08",     2'b10, 1'b0, 'h008, 32'hDEAD_BEEF));
    tbl.push_back(st("sw_04",     2'b10, 'h004, 32'h0000_80F0, 32'h0000_80F0));
    tbl.push_back(ld("lb_04",     2'b00, 1'b0, 'h004, 32'hFFFF_FFF0));
    tbl.push_back(ld("lbu_04",    2'b00, 1'b1, 'h004, 32'h0000_00F0));
    tbl.push_back(ld("lh_04",     2'b01, 1'b0, 'h004, 32'hFFFF_80F0));
    tbl.push_back(ld("lhu_06",    2'b01, 1'b1, 'h006, 32'h0000_0000));
    tbl.push_back(ld("lb_05",     2'b00, 1'b0, 'h005, 32'hFFFF_FF80));
    tbl.push_back(st("sw_0c",     2'b10, 'h00C, 32'h1122_3344, 32'h1122_3344));
    tbl.push_back(st("sb_0d",     2'b00, 'h00D, 32'hFFFF_FFAB, 32'h1122_AB44));
    tbl.push_back(ld("lw_0c_a",   2'b10, 1'b0, 'h00C, c1));
    tbl.push_back(st("sh_0e",     2'b01, 'h00E, 32'h5555_CAFE, 32'hCAFE_AB44));
    tbl.push_back(ld("lbu_0f",    2'b00, 1'b1, 'h00F, 32'h0000_00CA));
    tbl.push_back(ld("lh_0e",     2'b01, 1'b0, 'h00E, 32'hFFFF_CAFE));
    tbl.push_back(st("sb_0c",     2'b00, 'h00C, 32'h0000_007F, 32'hCAFE_AB7F));
    tbl.push_back(ld("lw_0c_b",   2'b10, 1'b0, 'h00C, c2));
    tbl.push_back(ld("lhu_0e",    2'b01, 1'b1, 'h00E, 32'h0000_CAFE));
    tbl.push_back(er("lw_mis2",   1'b0, 2'b10, 'h002));
    tbl.push_back(er("sh_mis1",   1'b1, 2'b01, 'h001));
    tbl.push_back(er("ld_size3",  1'b0, 2'b11, 'h000));
    tbl.push_back(er("sw_mis6",   1'b1, 2'b10, 'h006));
    tbl.push_back(er("lh_mis3",   1'b0, 2'b01, 'h003));
    tbl.push_back(er("st_size3",  1'b1, 2'b11, 'h008));
    tbl.push_back(st("sw_top",    2'b10, (1 << AW2) - 4, 32'h0BAD_F00D, 32'h0BAD_F00D));
    tbl.push_back(ld("lw_top",    2'b10, 1'b0, (1 << AW2) - 4, 32'h0BAD_F00D));
    tbl.push_back(ld("lw_08_b",   2'b10, 1'b0, 'h008, 32'hDEAD_BEEF));
`ifndef LSU_SUBWORD_EN
    foreach (tbl[i]) begin
      if (!tbl[i].err && tbl[i].size != 2'b10) tbl[i] = er(tbl[i].nm, tbl[i].we, tbl[i].size, int'(tbl[i].addr));
    end
`endif

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl",  64'({bus.memRead, bus.memWrite, bus.resp_valid, bus.resp_err, bus.req_ready}), 64'(0));
    chk("rst_addr",  64'(bus.dataAddress), 64'(0));
    chk("rst_wmd",   64'(bus.writeMemData), 64'(0));
    chk("rst_rdata", 64'(bus.resp_rdata), 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst", 64'({bus.req_ready, bus.memRead, bus.memWrite}), 64'(3'b100));

    foreach (tbl[i]) begin
      issue(tbl[i]);
      drain();
    end

    // back-to-back: request held valid while busy; the second is taken on return to IDLE
    @(posedge clk); #1;
    v = ld("b2b_first", 2'b10, 1'b0, 'h008, 32'hDEAD_BEEF);
    drive(v);
    exp_q.push_back(v);
    @(negedge clk); #1;
    chk("b2b_ready_idle", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
    v = ld("b2b_second", 2'b10, 1'b0, 'h004, 32'h0000_80F0);
    drive(v);
    exp_q.push_back(v);
    @(negedge clk); #1;
    chk("b2b_ready_busy", 64'(bus.req_ready), 64'(0));
    wait_ready("b2b_second");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();

    // abort by reset while the captured read word is being processed
    issue(st("sw_14", 2'b10, 'h014, 32'h0102_0304, 32'h0102_0304));
    drain();
    @(posedge clk); #1;
`ifdef LSU_SUBWORD_EN
    drive(st("abort_sb", 2'b00, 'h014, 32'h0000_00EE, 32'h0102_03EE));
`else
    drive(ld("abort_lw", 2'b10, 1'b0, 'h014, 32'h0102_0304));
`endif
    @(negedge clk); #1;
    chk("abort_accept", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("abort_quiet", 64'({bus.memRead, bus.memWrite, bus.resp_valid}), 64'(0));
    end
    chk("abort_no_resp", 64'(obs_q.size()), 64'(0));
    issue(ld("lw_14_after", 2'b10, 1'b0, 'h014, 32'h0102_0304));
    drain();
`ifndef LSU_SUBWORD_EN
    issue(er("sb_nosub", 1'b1, 2'b00, 'h014));
    drain();
`endif

    chk("strobe_overlap", 64'(overlap), 64'(0));
    chk("spurious_resp", 64'(obs_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
